id_ex_stage: RTL and testbench

//   ID/EX pipeline register plus EX operand-forwarding network. Latches decoded operands and controls from ID.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/fwd_mux.sv | 29 ++
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 tb/tb_id_ex_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, ALU encodings and EX control bundle for the ID/EX stage
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0100;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ex_ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - selects the freshest value of one source register (EX/MEM over MEM/WB over stored)
module fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] idx,
  input  logic [DATA_W-1:0] stored,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] value
);

  // r0 is never a forwarding target: producers naming it are discarding their result
  always_comb begin
    value = stored;
    if (idx != '0) begin
      if (exmem_reg_write && exmem_rd == idx) begin
        value = exmem_result;
      end else if (memwb_reg_write && memwb_rd == idx) begin
        value = memwb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register, load-use bubble and EX operand forwarding
// Optional feature macro ID_EX_FWD_EN: without it, every RAW on the EX instruction stalls instead.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_AW = mips_pkg::REG_AW,
  parameter int CTRL_W = mips_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_alu_a,
  output logic [DATA_W-1:0] ex_alu_b,
  output logic [CTRL_W-1:0] ex_alu_ctrl,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);

  logic              valid_q;
  ex_ctrl_t          ctrl_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [CTRL_W-1:0] alu_ctrl_q;
  logic              alu_src_q;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic              producer;
  logic              rs_hit;
  logic              rt_hit;

`ifdef ID_EX_FWD_EN
  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .idx             (rs_q),
    .stored          (rs_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .value           (fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .idx             (rt_q),
    .stored          (rt_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .value           (fwd_rt)
  );

  // only a load's value is still unavailable one cycle later
  assign producer = ctrl_q.mem_read;
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result, rs_q, rt_q};
  assign fwd_rs   = rs_data_q;
  assign fwd_rt   = rt_data_q;
  assign producer = ctrl_q.mem_read | ctrl_q.reg_write;
`endif

  // rt is a true source only for R-type ALU ops and for stores (store data)
  assign rs_hit = (rd_q == id_rs);
  assign rt_hit = (rd_q == id_rt) && (!id_alu_src || id_mem_write);

  assign load_use_stall = !flush && valid_q && producer && (rd_q != REG_ZERO[REG_AW-1:0])
                          && id_valid && (rs_hit || rt_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alu_ctrl_q <= ALU_ADD;
      alu_src_q  <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (stall) begin
`ifdef ID_EX_FWD_EN
      // capture producers retiring while we wait, they won't be on the bypass later
      rs_data_q <= fwd_rs;
      rt_data_q <= fwd_rt;
`endif
    end else if (load_use_stall) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q              <= id_valid;
      ctrl_q.reg_write     <= id_valid & id_reg_write;
      ctrl_q.mem_read      <= id_valid & id_mem_read;
      ctrl_q.mem_write     <= id_valid & id_mem_write;
      ctrl_q.mem_to_reg    <= id_valid & id_mem_to_reg;
      rs_q                 <= id_rs;
      rt_q                 <= id_rt;
      rd_q                 <= id_rd;
      rs_data_q            <= id_rs_data;
      rt_data_q            <= id_rt_data;
      imm_q                <= id_imm;
      alu_ctrl_q           <= id_alu_ctrl;
      alu_src_q            <= id_alu_src;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_alu_a      = fwd_rs;
  assign ex_alu_b      = alu_src_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_alu_ctrl   = alu_ctrl_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = valid_q & ctrl_q.reg_write;
  assign ex_mem_read   = valid_q & ctrl_q.mem_read;
  assign ex_mem_write  = valid_q & ctrl_q.mem_write;
  assign ex_mem_to_reg = valid_q & ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and random checks of id_ex_stage against a behavioural EX-slot model
// Honours ID_EX_FWD_EN the same way the design does.
module tb_id_ex_stage;
  import mips_pkg::*;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic stall = 0, flush = 0, id_valid = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0;
  logic [31:0] id_rs_data = 0, id_rt_data = 0, id_imm = 0;
  logic [3:0] id_alu_ctrl = 0;
  logic id_alu_src = 0, id_reg_write = 0, id_mem_read = 0, id_mem_write = 0, id_mem_to_reg = 0;
  logic exmem_reg_write = 0, memwb_reg_write = 0;
  logic [4:0] exmem_rd = 0, memwb_rd = 0;
  logic [31:0] exmem_result = 0, memwb_result = 0;
  logic load_use_stall, ex_valid;
  logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
  logic [3:0] ex_alu_ctrl;
  logic [4:0] ex_rd;
  logic ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alu_ctrl(id_alu_ctrl),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_alu_a(ex_alu_a),
    .ex_alu_b(ex_alu_b), .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  always #5 clk = ~clk;

  // Behavioural picture of the instruction sitting in EX
  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, imm;
    logic [3:0]  ctrl;
    logic        src, rw, mr, mw, m2r;
  } ex_rec_t;

  ex_rec_t m = '{default: '0};

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] stored);
    if (!FWD || idx == 5'd0) return stored;
    if (exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd == idx) return memwb_result;
    return stored;
  endfunction

  function automatic logic mdl_lus();
    logic uses_rt, prod;
    uses_rt = !id_alu_src || id_mem_write;
    prod    = m.mr || (!FWD && m.rw);
    return !flush && m.valid && prod && m.rd != 5'd0 && id_valid &&
           (m.rd == id_rs || (uses_rt && m.rd == id_rt));
  endfunction

  function automatic logic [31:0] mdl_a();
    return fwd(m.rs, m.a);
  endfunction

  function automatic logic [31:0] mdl_sd();
    return fwd(m.rt, m.b);
  endfunction

  function automatic logic [31:0] mdl_b();
    return m.src ? m.imm : fwd(m.rt, m.b);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m = '{default: '0};
    end else begin
      logic bubble;
      logic [31:0] na, nb;
      bubble = mdl_lus();
      if (flush || (!stall && bubble)) begin
        m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0;
      end else if (stall) begin
        na = fwd(m.rs, m.a);
        nb = fwd(m.rt, m.b);
        m.a = na;
        m.b = nb;
      end else begin
        m = '{valid: id_valid, rs: id_rs, rt: id_rt, rd: id_rd, a: id_rs_data, b: id_rt_data,
              imm: id_imm, ctrl: id_alu_ctrl, src: id_alu_src,
              rw: id_valid & id_reg_write, mr: id_valid & id_mem_read,
              mw: id_valid & id_mem_write, m2r: id_valid & id_mem_to_reg};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                         input logic [31:0] exp);
    chk(name, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  // Per-cycle comparison of DUT against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_valid", ex_valid, m.valid);
      chk("cyc_lus", load_use_stall, mdl_lus());
      chk("cyc_rw", ex_reg_write, m.valid & m.rw);
      chk("cyc_mr", ex_mem_read, m.valid & m.mr);
      chk("cyc_mw", ex_mem_write, m.valid & m.mw);
      chk("cyc_m2r", ex_mem_to_reg, m.valid & m.m2r);
      if (m.valid) begin
        chk("cyc_rd", ex_rd, m.rd);
        chk("cyc_ctrl", ex_alu_ctrl, m.ctrl);
        chk("cyc_a", ex_alu_a, mdl_a());
        chk("cyc_b", ex_alu_b, mdl_b());
        chk("cyc_sd", ex_store_data, mdl_sd());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] da, input logic [31:0] db,
                        input logic [31:0] imm, input logic [3:0] op, input logic src,
                        input logic rw, input logic mr, input logic mw, input logic m2r);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = da; id_rt_data = db;
    id_imm = imm; id_alu_ctrl = op; id_alu_src = src; id_reg_write = rw;
    id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  task automatic id_nop();
    id_set(0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
  endtask

  task automatic fw_set(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                        input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
    exmem_reg_write = erw; exmem_rd = erd; exmem_result = eres;
    memwb_reg_write = wrw; memwb_rd = wrd; memwb_result = wres;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_lit({tag, "_valid"}, ex_valid, m.valid, 0);
    chk_lit({tag, "_lus"}, load_use_stall, mdl_lus(), 0);
    chk_lit({tag, "_a"}, ex_alu_a, mdl_a(), 0);
    chk_lit({tag, "_b"}, ex_alu_b, mdl_b(), 0);
    chk_lit({tag, "_sd"}, ex_store_data, mdl_sd(), 0);
    chk_lit({tag, "_rd"}, ex_rd, m.rd, 0);
    chk_lit({tag, "_ctrl"}, ex_alu_ctrl, m.ctrl, ALU_ADD);
    chk(tag, {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
  endtask

  initial begin
    // reset with ID presenting a would-be hazard: stage is empty so no stall
    id_set(1, 3, 3, 3, 32'h1, 32'h2, 32'h3, ALU_SUB, 0, 1, 1, 0, 0);
    fw_set(1, 3, 32'h55, 1, 3, 32'h66);
    #2 rst_n = 0;
    #1 chk_reset_outputs("reset");
    step(); step();
    #2 rst_n = 1;
    id_nop(); fw_set(0, 0, 0, 0, 0, 0);
    step();

    // add r3,r1,r2 then sub r4,r3,r1
    id_set(1, 1, 2, 3, 32'h5, 32'h6, 0, ALU_ADD, 0, 1, 0, 0, 0);
    step();
    id_set(1, 3, 1, 4, 32'h99, 32'h7, 0, ALU_SUB, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk_lit("addsub_lus", load_use_stall, mdl_lus(), FWD ? 0 : 1);
    step();
    fw_set(1, 3, 32'h10, 0, 0, 0);
    @(negedge clk);
    if (FWD) begin
      chk_lit("addsub_valid", ex_valid, m.valid, 1);
      chk_lit("addsub_a", ex_alu_a, mdl_a(), 32'h10);
      chk_lit("addsub_b", ex_alu_b, mdl_b(), 32'h7);
      chk_lit("addsub_ctrl", ex_alu_ctrl, m.ctrl, ALU_SUB);
    end else begin
      chk_lit("addsub_bubble", ex_valid, m.valid, 0);
      step();
      @(negedge clk);
      chk_lit("addsub_valid", ex_valid, m.valid, 1);
      chk_lit("addsub_a", ex_alu_a, mdl_a(), 32'h99);
    end

    // EX/MEM and MEM/WB both write r5; EX/MEM wins
    id_set(1, 5, 5, 6, 32'h1, 32'h2, 0, ALU_OR, 0, 1, 0, 0, 0);
    fw_set(0, 0, 0, 0, 0, 0);
    step();
    id_nop();
    fw_set(1, 5, 32'hA, 1, 5, 32'hB);
    @(negedge clk);
    chk_lit("prio_a", ex_alu_a, mdl_a(), FWD ? 32'hA : 32'h1);
    chk_lit("prio_sd", ex_store_data, mdl_sd(), FWD ? 32'hA : 32'h2);

    // lw r2 followed by add r6,r2,r2
    id_set(1, 0, 0, 2, 0, 0, 32'h4, ALU_ADD, 1, 1, 1, 0, 1);
    fw_set(0, 0, 0, 0, 0, 0);
    step();
    id_set(1, 2, 2, 6, 32'h55, 32'h55, 0, ALU_ADD, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk_lit("lu_stall", load_use_stall, mdl_lus(), 1);
    chk_lit("lu_mr", ex_mem_read, m.valid & m.mr, 1);
    step();
    fw_set(1, 2, 32'hBAD, 0, 0, 0);
    @(negedge clk);
    chk_lit("lu_bubble", ex_valid, m.valid, 0);
    chk_lit("lu_stall_off", load_use_stall, mdl_lus(), 0);
    step();
    fw_set(0, 0, 0, 1, 2, 32'h1234);
    @(negedge clk);
    chk_lit("lu_valid", ex_valid, m.valid, 1);
    chk_lit("lu_a", ex_alu_a, mdl_a(), FWD ? 32'h1234 : 32'h55);
    chk_lit("lu_b", ex_alu_b, mdl_b(), FWD ? 32'h1234 : 32'h55);

    // r0 is never forwarded
    id_set(1, 0, 0, 7, 0, 0, 0, ALU_AND, 0, 1, 0, 0, 0);
    fw_set(0, 0, 0, 0, 0, 0);
    step();
    id_nop();
    fw_set(1, 0, 32'hFFFF, 1, 0, 32'hFFFF);
    @(negedge clk);
    chk_lit("r0_a", ex_alu_a, mdl_a(), 0);
    chk_lit("r0_sd", ex_store_data, mdl_sd(), 0);

    // sw with rt=r8 held by a 3-cycle stall while the MEM/WB producer retires
    id_set(1, 0, 8, 0, 0, 32'h77, 32'h8, ALU_ADD, 1, 0, 0, 1, 0);
    fw_set(0, 0, 0, 0, 0, 0);
    step();
    id_nop();
    stall = 1;
    fw_set(0, 0, 0, 1, 8, 32'hCAFE);
    @(negedge clk);
    chk_lit("stl_sd0", ex_store_data, mdl_sd(), FWD ? 32'hCAFE : 32'h77);
    step();
    fw_set(0, 0, 0, 0, 0, 0);
    step(); step();
    stall = 0;
    @(negedge clk);
    chk_lit("stl_sd", ex_store_data, mdl_sd(), FWD ? 32'hCAFE : 32'h77);
    chk_lit("stl_b", ex_alu_b, mdl_b(), 32'h8);
    chk_lit("stl_mw", ex_mem_write, m.valid & m.mw, 1);

    // flush+stall beats a pending load-use, then async reset mid-stream
    id_set(1, 0, 0, 9, 0, 0, 0, ALU_ADD, 1, 1, 1, 0, 1);
    step();
    id_set(1, 9, 0, 10, 32'h3, 32'h4, 0, ALU_SLT, 0, 1, 0, 0, 0);
    flush = 1; stall = 1;
    @(negedge clk);
    chk_lit("fl_lus", load_use_stall, mdl_lus(), 0);
    step();
    @(negedge clk);
    chk_lit("fl_valid", ex_valid, m.valid, 0);
    chk_lit("fl_mr", ex_mem_read, m.valid & m.mr, 0);
    flush = 0; stall = 0;
    id_set(1, 1, 2, 10, 32'h3, 32'h4, 0, ALU_SLT, 0, 1, 0, 0, 0);
    step();
    @(negedge clk);
    chk_lit("post_fl_valid", ex_valid, m.valid, 1);
    step();
    #2 rst_n = 0;
    #1 chk_reset_outputs("midrst");
    step();
    #2 rst_n = 1;

    // randomized traffic on a small register window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      step();
      id_set(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom(), $urandom(), $urandom(),
             4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      fw_set(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom(),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom());
      flush = ($urandom_range(0, 15) == 0);
      stall = ($urandom_range(0, 5) == 0);
    end
    step();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
